cyc_ext_gen: RTL and testbench

- Parametrised cyclic-extension generator for the preprocessing chain.
- Accepts a stream of complex samples per transform block and forwards them unchanged. After the last sample of the block, it appends an extension of runtime-selected length.
- Extension content is either a cyclic repeat of the block's first samples or zero padding.
- Valid/ready on both sides replaces the fixed internal FIFO; the block sits between the sample source and the DFT input buffer.

---
 rtl/cyc_ext_gen.sv | 177 +++++++++++++++++
 tb/tb_cyc_ext_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cyc_ext_gen.sv
// Cyclic-extension generator: forwards one block of samples unchanged, then
// appends a runtime-sized extension (repeat of the block head or zero padding).
module cyc_ext_gen #(
    parameter int DATA_W  = 32,
    parameter int MAX_EXT = 16,
    parameter int LEN_W   = 11,
    parameter int EXT_W   = 5
) (
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sof_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [LEN_W-1:0]  trans_len_i,
    input  logic [EXT_W-1:0]  ext_len_i,
    input  logic              mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sof_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int IDX_W = (MAX_EXT > 1) ? $clog2(MAX_EXT) : 1;
    localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(MAX_EXT);

    typedef enum logic [1:0] {IDLE, PASS, EXT} state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_r;
    logic [EXT_W-1:0]   ext_r;
    logic               mode_r;
    logic [LEN_W-1:0]   cnt;
    logic [EXT_W-1:0]   ecnt;
    logic [DATA_W-1:0]  head_buf [MAX_EXT];

    logic               slot_free;
    logic               accept;
    logic               start;
    logic               at_last;
    logic               ext_done;
    logic               head_we;
    logic [IDX_W-1:0]   head_idx;
    logic [DATA_W-1:0]  ext_rd;
    logic [LEN_W-1:0]   len_new;
    logic [EXT_W-1:0]   ext_new;

    // A zero-length block is treated as a single-sample block.
    function automatic logic [LEN_W-1:0] fix_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    // Extension saturates at the head-buffer depth and at the block length.
    function automatic logic [EXT_W-1:0] clamp_ext(input logic [EXT_W-1:0] ext,
                                                   input logic [LEN_W-1:0] len);
        logic [EXT_W-1:0] sat;
        sat = (ext > EXT_MAX) ? EXT_MAX : ext;
        return (LEN_W'(sat) > len) ? EXT_W'(len) : sat;
    endfunction

    assign slot_free  = !out_valid_o || out_ready_i;
    assign in_ready_o = slot_free && (state != EXT);
    assign accept     = in_valid_i && in_ready_o;
    assign start      = accept && in_sof_i;
    assign busy_o     = (state != IDLE);

    assign len_new  = fix_len(trans_len_i);
    assign ext_new  = clamp_ext(ext_len_i, len_new);
    assign at_last  = (cnt == len_r - LEN_W'(1));
    assign ext_done = (ecnt == ext_r - EXT_W'(1));

    // Head capture: the sof sample goes to slot 0, later samples by index while below E.
    assign head_we  = start ? (ext_new != '0)
                            : (accept && (state == PASS) && (cnt < LEN_W'(ext_r)));
    assign head_idx = start ? '0 : cnt[IDX_W-1:0];
    assign ext_rd   = head_buf[ecnt[IDX_W-1:0]];

    always_ff @(posedge clk_sys) begin
        if (head_we) begin
            head_buf[head_idx] <= in_data_i;
        end
    end

    // Control and output register stage
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state       <= IDLE;
            len_r       <= '0;
            ext_r       <= '0;
            mode_r      <= 1'b0;
            cnt         <= '0;
            ecnt        <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sof_o   <= 1'b0;
            out_last_o  <= 1'b0;
            err_o       <= 1'b0;
        end else if (clr_i) begin
            state       <= IDLE;
            len_r       <= '0;
            ext_r       <= '0;
            mode_r      <= 1'b0;
            cnt         <= '0;
            ecnt        <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sof_o   <= 1'b0;
            out_last_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
                out_sof_o   <= 1'b0;
                out_last_o  <= 1'b0;
            end
            if (start) begin
                // A sof inside PASS abandons the running block without extension.
                if ((trans_len_i == '0) || (state == PASS)) begin
                    err_o <= 1'b1;
                end
                len_r       <= len_new;
                ext_r       <= ext_new;
                mode_r      <= mode_i;
                out_valid_o <= 1'b1;
                out_data_o  <= in_data_i;
                out_sof_o   <= 1'b1;
                out_last_o  <= (len_new == LEN_W'(1)) && (ext_new == '0);
                cnt         <= LEN_W'(1);
                ecnt        <= '0;
                if (len_new != LEN_W'(1)) begin
                    state <= PASS;
                end else if (ext_new != '0) begin
                    state <= EXT;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    PASS: begin
                        if (accept) begin
                            out_valid_o <= 1'b1;
                            out_data_o  <= in_data_i;
                            out_sof_o   <= 1'b0;
                            out_last_o  <= at_last && (ext_r == '0);
                            if (at_last) begin
                                state <= (ext_r == '0) ? IDLE : EXT;
                                ecnt  <= '0;
                            end else begin
                                cnt <= cnt + LEN_W'(1);
                            end
                        end
                    end
                    EXT: begin
                        if (slot_free) begin
                            out_valid_o <= 1'b1;
                            out_data_o  <= mode_r ? '0 : ext_rd;
                            out_sof_o   <= 1'b0;
                            out_last_o  <= ext_done;
                            if (ext_done) begin
                                state <= IDLE;
                            end else begin
                                ecnt <= ecnt + EXT_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cyc_ext_gen.sv
// Directed bench for cyc_ext_gen: table of block configurations plus
// hand-written sequences for truncation, clear, zero length and reset.
module tb_cyc_ext_gen;

    localparam int DATA_W  = 32;
    localparam int MAX_EXT = 16;
    localparam int LEN_W   = 11;
    localparam int EXT_W   = 5;

    logic              clk_sys = 1'b0;
    logic              rst_sys_n = 1'b0;
    logic              clr_i = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready_o;
    logic              in_sof = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [LEN_W-1:0]  trans_len = '0;
    logic [EXT_W-1:0]  ext_len = '0;
    logic              mode = 1'b0;
    logic              out_valid_o;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data_o;
    logic              out_sof_o;
    logic              out_last_o;
    logic              busy_o;
    logic              err_o;

    cyc_ext_gen #(
        .DATA_W (DATA_W),
        .MAX_EXT(MAX_EXT),
        .LEN_W  (LEN_W),
        .EXT_W  (EXT_W)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .clr_i      (clr_i),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_o),
        .in_sof_i   (in_sof),
        .in_data_i  (in_data),
        .trans_len_i(trans_len),
        .ext_len_i  (ext_len),
        .mode_i     (mode),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready),
        .out_data_o (out_data_o),
        .out_sof_o  (out_sof_o),
        .out_last_o (out_last_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial forever #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              sof;
        logic              last;
        int                cyc;
    } beat_t;

    typedef struct {
        logic [LEN_W-1:0]  len;
        logic [EXT_W-1:0]  ext;
        logic              md;
        int                rnd;
        logic [DATA_W-1:0] base;
        int                e_exp;
    } vec_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t prev;
    vec_t  vecs[10];
    int    n_vec  = 0;
    int    n_err  = 0;
    int    cyc    = 0;
    int    lowcnt = 0;
    int    rmode  = 0;
    logic  hold   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Output monitor: collects transfers and checks that stalled outputs hold.
    always @(negedge clk_sys) begin
        cyc++;
        if (!in_ready_o) lowcnt++;
        if (hold && rst_sys_n) begin
            chk("hold stable", 64'({out_valid_o, out_sof_o, out_last_o, out_data_o}),
                64'({1'b1, prev.sof, prev.last, prev.d}));
        end
        if (rst_sys_n && out_valid_o && out_ready) begin
            got_q.push_back('{out_data_o, out_sof_o, out_last_o, cyc});
        end
        hold = out_valid_o && !out_ready && rst_sys_n && !clr_i;
        prev = '{out_data_o, out_sof_o, out_last_o, cyc};
    end

    // Downstream ready: 0 = always ready, 1 = random 50%, 2 = never ready.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_rmode(input int m);
        rmode = m;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic push_sample(input logic sof, input logic [DATA_W-1:0] d,
                               input logic [LEN_W-1:0] len, input logic [EXT_W-1:0] ext,
                               input logic md);
        logic taken;
        in_valid  = 1'b1;
        in_sof    = sof;
        in_data   = d;
        trans_len = len;
        ext_len   = ext;
        mode      = md;
        taken     = 1'b0;
        for (int t = 0; t < 300 && !taken; t++) begin
            @(negedge clk_sys);
            taken = in_ready_o;
            @(posedge clk_sys);
            #1;
        end
        if (!taken) chk("input accept timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic add_block(input logic [DATA_W-1:0] base, input int len, input int e,
                             input logic md);
        for (int i = 0; i < len; i++)
            exp_q.push_back('{base + DATA_W'(i), (i == 0), (i == len - 1) && (e == 0), 0});
        for (int j = 0; j < e; j++)
            exp_q.push_back('{md ? '0 : base + DATA_W'(j), 1'b0, (j == e - 1), 0});
    endtask

    task automatic check_stream(input string name, input bit timing);
        int n;
        for (int t = 0; t < 400 && got_q.size() < exp_q.size(); t++) @(negedge clk_sys);
        repeat (3) @(negedge clk_sys);
        chk({name, " beat count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s beat%0d", name, i),
                64'({got_q[i].sof, got_q[i].last, got_q[i].d}),
                64'({exp_q[i].sof, exp_q[i].last, exp_q[i].d}));
        end
        if (timing && n > 0 && got_q.size() == exp_q.size())
            chk({name, " span"}, 64'(got_q[n-1].cyc - got_q[0].cyc), 64'(n - 1));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid_o), 64'(0));
        chk({tag, " out_data"},  64'(out_data_o),  64'(0));
        chk({tag, " out_sof"},   64'(out_sof_o),   64'(0));
        chk({tag, " out_last"},  64'(out_last_o),  64'(0));
        chk({tag, " in_ready"},  64'(in_ready_o),  64'(1));
        chk({tag, " busy"},      64'(busy_o),      64'(0));
        chk({tag, " err"},       64'(err_o),       64'(0));
    endtask

    initial begin
        vecs[0] = '{11'd8,  5'd3,  1'b0, 0, 32'h0000_0000, 3};
        vecs[1] = '{11'd8,  5'd3,  1'b1, 0, 32'h0000_0000, 3};
        vecs[2] = '{11'd4,  5'd20, 1'b0, 0, 32'h0000_00A0, 4};
        vecs[3] = '{11'd16, 5'd5,  1'b0, 1, 32'h0000_1000, 5};
        vecs[4] = '{11'd16, 5'd5,  1'b0, 1, 32'h0000_2000, 5};
        vecs[5] = '{11'd16, 5'd5,  1'b0, 1, 32'h0000_3000, 5};
        vecs[6] = '{11'd1,  5'd0,  1'b0, 0, 32'h0000_0077, 0};
        vecs[7] = '{11'd2,  5'd16, 1'b0, 0, 32'h0000_0400, 2};
        vecs[8] = '{11'd20, 5'd16, 1'b0, 0, 32'h0000_0500, 16};
        vecs[9] = '{11'd20, 5'd17, 1'b1, 0, 32'h0000_0600, 16};

        repeat (2) @(posedge clk_sys);
        #1;
        check_idle_outputs("reset");
        rst_sys_n = 1'b1;
        @(posedge clk_sys);
        #1;

        for (int v = 0; v < 10; v++) begin
            set_rmode(vecs[v].rnd);
            lowcnt = 0;
            add_block(vecs[v].base, int'(vecs[v].len), vecs[v].e_exp, vecs[v].md);
            for (int i = 0; i < int'(vecs[v].len); i++)
                push_sample(i == 0, vecs[v].base + DATA_W'(i), vecs[v].len, vecs[v].ext, vecs[v].md);
            check_stream($sformatf("vec%0d", v), vecs[v].rnd == 0);
            if (vecs[v].rnd == 0)
                chk($sformatf("vec%0d in_ready low cycles", v), 64'(lowcnt), 64'(vecs[v].e_exp));
            chk($sformatf("vec%0d err", v), 64'(err_o), 64'(0));
        end
        set_rmode(0);

        // Truncated block: sof after 5 samples of an 8-sample block.
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{32'h100 + DATA_W'(i), (i == 0), 1'b0, 0});
        add_block(32'h200, 6, 2, 1'b0);
        for (int i = 0; i < 5; i++) push_sample(i == 0, 32'h100 + DATA_W'(i), 11'd8, 5'd3, 1'b0);
        for (int i = 0; i < 6; i++) push_sample(i == 0, 32'h200 + DATA_W'(i), 11'd6, 5'd2, 1'b0);
        check_stream("trunc", 1'b1);
        chk("trunc err", 64'(err_o), 64'(1));
        clr_i = 1'b1;
        @(posedge clk_sys);
        #1;
        clr_i = 1'b0;
        chk("clr err", 64'(err_o), 64'(0));

        // Clear while an output is stalled mid-block.
        set_rmode(2);
        push_sample(1'b1, 32'h900, 11'd8, 5'd3, 1'b0);
        chk("stall busy", 64'(busy_o), 64'(1));
        chk("stall valid", 64'(out_valid_o), 64'(1));
        clr_i = 1'b1;
        @(posedge clk_sys);
        #1;
        clr_i = 1'b0;
        chk("clr drop valid", 64'(out_valid_o), 64'(0));
        chk("clr drop busy", 64'(busy_o), 64'(0));
        set_rmode(0);
        repeat (2) @(negedge clk_sys);
        chk("clr no output", 64'(got_q.size()), 64'(0));

        // Samples before any sof are dropped; zero length acts as length 1.
        for (int i = 0; i < 3; i++) push_sample(1'b0, 32'hDEAD, 11'd8, 5'd3, 1'b0);
        exp_q.push_back('{32'h55, 1'b1, 1'b0, 0});
        exp_q.push_back('{32'h55, 1'b0, 1'b1, 0});
        push_sample(1'b1, 32'h55, 11'd0, 5'd3, 1'b0);
        check_stream("len0", 1'b1);
        chk("len0 err", 64'(err_o), 64'(1));

        // Asynchronous reset in the middle of the extension.
        for (int i = 0; i < 8; i++) push_sample(i == 0, 32'h700 + DATA_W'(i), 11'd8, 5'd3, 1'b0);
        @(posedge clk_sys);
        #1;
        chk("mid-ext busy", 64'(busy_o), 64'(1));
        chk("mid-ext in_ready", 64'(in_ready_o), 64'(0));
        rst_sys_n = 1'b0;
        #1;
        check_idle_outputs("async rst");
        got_q.delete();
        exp_q.delete();
        @(posedge clk_sys);
        #1;
        rst_sys_n = 1'b1;
        @(posedge clk_sys);
        #1;
        add_block(32'h800, 4, 2, 1'b0);
        for (int i = 0; i < 4; i++) push_sample(i == 0, 32'h800 + DATA_W'(i), 11'd4, 5'd2, 1'b0);
        check_stream("post rst", 1'b1);
        chk("post rst err", 64'(err_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
